video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Video stream source (transmitter) for the image filter path. Generates vs/hs/de raster timing and Y/U/V test
//  pixels in the exact form filter_top_5x5 consumes on i_vs/i_hs/i_de/i_y/i_u/i_v. Used as the bench/FPGA stimulus
//  source ahead of the 5x5 filter. Frame-based run control with start/stop/single-frame modes.
// PARAMETERS
//  DATA_WIDTH  8   pixel component width
//  H_ACTIVE    16  active pixels per line
//  H_FP        2   horizontal front porch (clocks)
//  H_SYNC      4   hs pulse width (clocks)
//  H_BP        2   horizontal back porch (clocks)
//  V_ACTIVE    8   active lines per frame
//  V_FP        1   vertical front porch (lines)
//  V_SYNC      2   vs pulse width (lines)
//  V_BP        1   vertical back porch (lines)
// PORTS
//  clk            in   1           clock, all logic rising-edge
//  rst            in   1           synchronous reset, active-high
//  i_start        in   1           1-cycle pulse: begin continuous frames (ignored unless IDLE)
//  i_stop         in   1           1-cycle pulse: stop after current frame completes
//  i_single       in   1           1-cycle pulse: emit exactly one frame (ignored unless IDLE)
//  i_pattern_sel  in   2           0 h-ramp, 1 v-ramp, 2 checker 8x8, 3 frame-count flat
//  o_busy         out  1           1 while state != IDLE
//  o_frame_done   out  1           1-cycle pulse on last cycle of each frame
//  o_vs           out  1           vertical sync, active-high
//  o_hs           out  1           horizontal sync, active-high
//  o_de           out  1           data enable (active pixel)
//  o_y/o_u/o_v    out  DATA_WIDTH  pixel components, 0 when o_de=0
// BEHAVIOUR
//  H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL=V_SYNC+V_BP+V_ACTIVE+V_FP. Order per line/frame: SYNC,BP,ACTIVE,FP.
//  Counters h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; h wraps -> v increments; v wraps at frame end.
//  Decode (from counters): hs = h_cnt<H_SYNC; vs = v_cnt<V_SYNC;
//   de = h in [H_SYNC+H_BP, +H_ACTIVE) AND v in [V_SYNC+V_BP, +V_ACTIVE). px=h-(H_SYNC+H_BP), ln=v-(V_SYNC+V_BP).
//  All outputs registered: 1-cycle latency from counter state; vs/hs/de/y/u/v/frame_done mutually aligned.
//  Pixels (de=1): u=v=1<<(DATA_WIDTH-1). sel0 y=px[DW-1:0]; sel1 y=ln[DW-1:0];
//   sel2 y=(px[3]^ln[3])?all-ones:0; sel3 y=frame_cnt (8b frame counter, wraps 255->0, zero-extended/truncated to DW).
//  i_pattern_sel sampled only at frame start (h=v=0); mid-frame changes take effect next frame.
//  FSM: IDLE -> RUN (i_start) | ONE (i_single); start+single same cycle -> ONE.
//   RUN: i_stop -> STOP_PEND; frame wrap -> stays RUN. STOP_PEND/ONE: at frame wrap -> IDLE.
//   Entering RUN/ONE: counters =0 in first non-IDLE cycle. i_start/i_single outside IDLE ignored.
//   i_stop in IDLE or ONE ignored; i_stop with i_start in IDLE -> stay IDLE (stop wins).
//  IDLE: counters held 0, all outputs 0. Frame never truncated by i_stop.
//  o_frame_done: high when output cycle corresponds to h=H_TOTAL-1,v=V_TOTAL-1; frame_cnt increments then.
//  Reset (any time, incl. mid-frame): next cycle state IDLE, counters 0, frame_cnt 0, every output 0.
// TESTING (defaults: H_TOTAL=24, V_TOTAL=12, 288 clk/frame)
//  1 i_single at T -> o_busy=1 T+1; o_hs first 1 at T+2 for 4 clk; o_vs 1 for 48 clk from T+2;
//    o_de first 1 at T+80; 128 de cycles total; o_frame_done at T+289; o_busy=0 at T+290.
//  2 sel0 -> each active line y=0..15, u=v=128; sel1 -> line k all y=k (0..7); sel2 -> y 0 px0-7, 255 px8-15.
//  3 i_start, i_stop mid-frame 2 -> frame 2 completes fully (128 de), then IDLE; exactly 2 frame_done pulses.
//  4 sel3 continuous 3 frames -> y=0,1,2 per frame; i_pattern_sel changed mid-frame applies next frame only.
//  5 rst mid-active-line -> next cycle all outputs 0, o_busy=0; i_start while RUN has no effect on counters.
//  6 i_start+i_stop same cycle in IDLE -> stays IDLE; i_start+i_single -> exactly one frame.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Raster timing and Y/U/V test-pattern source for the 5x5 filter path.
// Frame-based run control: continuous, stop-after-frame, single frame.
module video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 16,
  parameter int H_FP       = 2,
  parameter int H_SYNC     = 4,
  parameter int H_BP       = 2,
  parameter int V_ACTIVE   = 8,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_single,
  input  logic [1:0]            i_pattern_sel,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_u,
  output logic [DATA_WIDTH-1:0] o_v
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // At least 4 bits so the 8x8 checker can always look at bit 3.
  localparam int HW = ($clog2(H_TOTAL) < 4) ? 4 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 4) ? 4 : $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_E = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYN_E = VW'(V_SYNC);
  localparam logic [HW-1:0] H_ACT_S = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_S = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [DATA_WIDTH-1:0] MID  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ONE,
    STOP_PEND
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [7:0]            frame_cnt;
  logic [1:0]            sel_q;
  logic                  act;
  logic                  h_last;
  logic                  v_last;
  logic                  wrap;
  logic                  hs_d;
  logic                  vs_d;
  logic                  de_d;
  logic [HW-1:0]         px;
  logic [VW-1:0]         ln;
  logic [DATA_WIDTH-1:0] y_d;

  assign act    = (state != IDLE);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign wrap   = act & h_last & v_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_single)                state_nxt = ONE;
        else if (i_start && !i_stop) state_nxt = RUN;
      end
      RUN: begin
        if (i_stop) state_nxt = wrap ? IDLE : STOP_PEND;
      end
      ONE, STOP_PEND: begin
        if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !act) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       frame_cnt <= '0;
    else if (wrap) frame_cnt <= frame_cnt + 1'b1;
  end

  // Pattern is latched once per frame so a frame never mixes patterns.
  always_ff @(posedge clk) begin
    if (rst)
      sel_q <= '0;
    else if (act && h_cnt == '0 && v_cnt == '0)
      sel_q <= i_pattern_sel;
  end

  assign hs_d = (h_cnt < H_SYN_E);
  assign vs_d = (v_cnt < V_SYN_E);
  assign de_d = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
  assign px   = h_cnt - H_ACT_S;
  assign ln   = v_cnt - V_ACT_S;

  always_comb begin
    y_d = '0;
    unique case (sel_q)
      2'd0: y_d = DATA_WIDTH'(px);
      2'd1: y_d = DATA_WIDTH'(ln);
      2'd2: y_d = (px[3] ^ ln[3]) ? ONES : '0;
      2'd3: y_d = DATA_WIDTH'(frame_cnt);
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !act) begin
      o_frame_done <= 1'b0;
      o_vs         <= 1'b0;
      o_hs         <= 1'b0;
      o_de         <= 1'b0;
      o_y          <= '0;
      o_u          <= '0;
      o_v          <= '0;
    end else begin
      o_frame_done <= wrap;
      o_vs         <= vs_d;
      o_hs         <= hs_d;
      o_de         <= de_d;
      o_y          <= de_d ? y_d : '0;
      o_u          <= de_d ? MID : '0;
      o_v          <= de_d ? MID : '0;
    end
  end

  // Busy also covers the registered last pixel of the frame.
  assign o_busy = act | o_frame_done;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed scenarios plus random run control,
// every cycle compared against a frame-position reference model.
module tb_video_pattern_gen;

  localparam int HT  = 24;
  localparam int VT  = 12;
  localparam int HA  = 16;
  localparam int VA  = 8;
  localparam int HS  = 4;
  localparam int VS  = 2;
  localparam int HST = 6;
  localparam int VST = 3;
  localparam int FR  = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_single = 1'b0;
  logic [1:0] i_pattern_sel = 2'd0;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_vs;
  logic       o_hs;
  logic       o_de;
  logic [7:0] o_y;
  logic [7:0] o_u;
  logic [7:0] o_v;

  video_pattern_gen dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_single     (i_single),
    .i_pattern_sel(i_pattern_sel),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_vs         (o_vs),
    .o_hs         (o_hs),
    .o_de         (o_de),
    .o_y          (o_y),
    .o_u          (o_u),
    .o_v          (o_v)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit m_act  = 0;
  bit m_cont = 0;
  int m_p    = 0;
  int m_fc   = 0;
  int m_sel  = 0;

  logic [4:0]  e_ctl;
  logic [23:0] e_pix;
  int de_seen;
  int fd_seen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outputs after an edge are a function of the frame position before it.
  task automatic model_step(input bit r, input bit st, input bit sp,
                            input bit sg, input int sel);
    int h, v, px, ln, y;
    bit hs, vs, de, fd;
    hs = 0; vs = 0; de = 0; fd = 0; y = 0;
    if (r) begin
      m_act = 0; m_cont = 0; m_p = 0; m_fc = 0;
      e_ctl = '0; e_pix = '0;
      return;
    end
    if (m_act) begin
      h  = m_p % HT;
      v  = m_p / HT;
      hs = (h < HS);
      vs = (v < VS);
      de = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
      px = h - HST;
      ln = v - VST;
      fd = (m_p == FR - 1);
      if (de) begin
        case (m_sel)
          0: y = px % 256;
          1: y = ln % 256;
          2: y = (((px / 8) ^ (ln / 8)) & 1) ? 255 : 0;
          default: y = m_fc;
        endcase
      end
      if (m_p == 0) m_sel = sel;
      if (sp) m_cont = 0;
      if (fd) begin
        m_fc = (m_fc + 1) % 256;
        m_p  = 0;
        if (!m_cont) m_act = 0;
      end else begin
        m_p++;
      end
    end else begin
      if (sg) begin
        m_act = 1; m_cont = 0;
      end else if (st && !sp) begin
        m_act = 1; m_cont = 1;
      end
      m_p = 0;
    end
    e_ctl = {m_act || fd, fd, vs, hs, de};
    e_pix = de ? {y[7:0], 8'd128, 8'd128} : 24'd0;
  endtask

  task automatic tick(input bit st, input bit sp, input bit sg, input bit r);
    rst = r; i_start = st; i_stop = sp; i_single = sg;
    model_step(r, st, sp, sg, int'(i_pattern_sel));
    @(posedge clk);
    #1;
    chk("ctl", {27'd0, o_busy, o_frame_done, o_vs, o_hs, o_de},
        {27'd0, e_ctl});
    chk("pix", {8'd0, o_y, o_u, o_v}, {8'd0, e_pix});
    de_seen += int'(o_de);
    fd_seen += int'(o_frame_done);
    rst = 0; i_start = 0; i_stop = 0; i_single = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    idle(3);

    // one frame per pattern
    for (int s = 0; s < 3; s++) begin
      i_pattern_sel = 2'(s);
      de_seen = 0; fd_seen = 0;
      tick(0, 0, 1, 0);
      idle(FR + 5);
      chk("single_de", de_seen, HA * VA);
      chk("single_fd", fd_seen, 1);
    end

    // continuous, stop mid frame 2
    i_pattern_sel = 2'd0;
    de_seen = 0; fd_seen = 0;
    tick(1, 0, 0, 0);
    idle(FR + 150);
    tick(0, 1, 0, 0);
    idle(FR);
    chk("stop_fd", fd_seen, 2);
    chk("stop_de", de_seen, 2 * HA * VA);
    chk("stop_busy", o_busy, 0);

    // frame counter pattern, selection changed mid frame
    tick(0, 0, 0, 1);
    i_pattern_sel = 2'd3;
    tick(1, 0, 0, 0);
    idle(2 * FR + 100);
    i_pattern_sel = 2'd0;
    idle(100);
    tick(0, 1, 0, 0);
    idle(FR + 10);

    // start while running, then reset mid active line
    tick(1, 0, 0, 0);
    idle(3 * HT + 10);
    tick(1, 0, 0, 0);
    idle(HT + 2);
    tick(0, 0, 0, 1);
    chk("rst_busy", o_busy, 0);
    idle(3);

    // start+stop stays idle; start+single gives one frame
    tick(1, 1, 0, 0);
    chk("ss_busy", o_busy, 0);
    idle(5);
    de_seen = 0; fd_seen = 0;
    tick(1, 0, 1, 0);
    idle(2 * FR);
    chk("sg_fd", fd_seen, 1);

    // random run control
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) i_pattern_sel = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
